counter_arbiter: RTL

Controller that shares one external 4-bit-class enable/sync-reset counter among NREQ requesters.
- Each requester asks for a timed interval of len[i] enabled counts.
- The block arbitrates, clears the counter, enables it until the terminal count is reached, then pulses done to the winner.
- Sits between requesting FSMs and the shared counter; it owns the counter's rst and en inputs and reads back its count.

---
 rtl/counter_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/counter_arbiter.sv
// Arbitrates NREQ requesters for one shared enable/sync-clear counter and times each grant.
// Define COUNTER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module counter_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*CW-1:0]   len_i,
    input  logic [CW-1:0]        cnt_val_i,
    output logic                 cnt_clr_o,
    output logic                 cnt_en_o,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic                 busy_o
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          N  = int'(NREQ);

    typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   len_q, len_d;
    logic [NREQ-1:0] gnt_q, gnt_d;

    logic [IW-1:0]   arb_base;
    logic [IW-1:0]   win_idx;
    logic            win_vld;
    int              cand;

`ifdef COUNTER_ARB_FIXED_PRIO_EN
    assign arb_base = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_inc;

    assign idx_inc = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
    // DONE re-arbitrates in the same cycle, so it searches from the already-advanced pointer.
    assign arb_base = (state_q == StDone) ? idx_inc : ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StDone) begin
            ptr_d = idx_inc;
        end else if (state_q == StRun && !req_i[idx_q]) begin
            ptr_d = idx_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Scan downward so the candidate closest to arb_base is the last one written.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(arb_base) + k) % N;
            if (req_i[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        gnt_d     = gnt_q;
        cnt_clr_o = 1'b0;
        cnt_en_o  = 1'b0;
        done_o    = '0;
        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    state_d        = StClear;
                    idx_d          = win_idx;
                    len_d          = len_i[int'(win_idx)*CW +: CW];
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                end
            end
            StClear: begin
                cnt_clr_o = 1'b1;
                state_d   = StRun;
            end
            StRun: begin
                // Losing the request takes priority over reaching terminal count.
                if (!req_i[idx_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end else if (cnt_val_i == len_q) begin
                    state_d = StDone;
                    gnt_d   = '0;
                end else begin
                    cnt_en_o = 1'b1;
                end
            end
            StDone: begin
                done_o[idx_q] = 1'b1;
                state_d       = StIdle;
                if (win_vld) begin
                    state_d        = StClear;
                    idx_d          = win_idx;
                    len_d          = len_i[int'(win_idx)*CW +: CW];
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = (state_q != StIdle);

endmodule
